joy_scanner: RTL
================

JOY_SCANNER -- requirements
Module: joy_scanner

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of daisy-chained DB9 ports (1..4).
REQ-002 SHALL have parameter BITS_PER_PORT, default 8, shift bits per port (1..16); N = NUM_PORTS*BITS_PER_PORT.
REQ-003 SHALL have parameter CLK_DIV, default 8, clk cycles per scan tick (>=2).
REQ-004 SHALL have clk  in  1  system clock; the block has one clock, and reset is synchronous and active-high.
REQ-005 SHALL have reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have mode_local  in  1  1 = local scan, 0 = forward I/O controller's scan.
REQ-007 SHALL have xjoy_clk, xjoy_load_n  in  1 each  shift clock and load from the I/O controller.
REQ-008 SHALL have joy_data  in  1  serial data from the shift-register chain, active-low buttons.
REQ-009 SHALL have joy_clk, joy_load_n  out  1 each  shift clock and parallel load to the chain.
REQ-010 SHALL have xjoy_data  out  1  serial data forwarded to the I/O controller.
REQ-011 SHALL have joy_state  out  N  latched button state, active-high.
REQ-012 SHALL have joy_valid  out  1  one-clk pulse when joy_state updates.

Function
REQ-013 SHALL assert a tick in the cycle where a free-running counter reaches CLK_DIV-1, then wrap it to 0, giving one tick every CLK_DIV clks.
REQ-014 SHALL use FSM states IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE, advancing only on a tick, except DONE.
REQ-015 In IDLE with mode_local=1, the FSM SHALL go to LOAD on tick.
REQ-016 LOAD SHALL drive joy_load_n=0 for one tick period, clear the bit counter, then go to SHIFT_LO.
REQ-017 SHIFT_LO SHALL drive joy_clk=0; on tick it SHALL sample joy_data into the shift register, go to SHIFT_HI, and drive joy_clk=1.
REQ-018 The first sampled bit SHALL land in bit N-1 of joy_state, and the last in bit 0.
REQ-019 SHIFT_HI SHALL increment the counter on tick; after bit N it SHALL go to DONE, otherwise to SHIFT_LO.
REQ-020 DONE SHALL last exactly one clk: joy_state <= bitwise NOT of the shift register, joy_valid=1 for that cycle, next state IDLE.
REQ-021 The local frame period SHALL be CLK_DIV*(2+2N) clks between joy_valid pulses.
REQ-022 With mode_local=1, joy_load_n SHALL be 1 and joy_clk SHALL be 1 outside LOAD and SHIFT_LO respectively, all from registers.
REQ-023 With mode_local=0, joy_clk=xjoy_clk and joy_load_n=xjoy_load_n SHALL be combinational; the FSM SHALL be held in IDLE, joy_valid=0, and joy_state held.
REQ-024 xjoy_data SHALL equal joy_data combinationally in both modes.
REQ-025 mode_local falling mid-scan SHALL abort to IDLE within one clk, with no joy_valid and joy_state unchanged.
REQ-026 mode_local rising SHALL start a fresh frame from IDLE; partial data SHALL never be latched.

Reset
REQ-027 On reset, the FSM SHALL go to IDLE and the tick counter, bit counter and shift register SHALL be set to 0.
REQ-028 On reset, joy_state SHALL be 0, joy_valid 0, and the registered joy_clk and joy_load_n SHALL be 1.
REQ-029 Reset asserted mid-frame SHALL abort on the next clk edge with no joy_valid.

Configuration
REQ-030 With macro JOY_MDSEL_EN defined, the block SHALL add output joy_select (reset 1) and output joy_state_ext [N-1:0] (reset 0).
REQ-031 With JOY_MDSEL_EN defined, joy_select SHALL toggle at each DONE; select=1 frames SHALL latch into joy_state, and select=0 frames into joy_state_ext.
REQ-032 With JOY_MDSEL_EN defined, joy_valid SHALL pulse only on select=0 frames, giving a period of 2*CLK_DIV*(2+2N).
REQ-033 Without JOY_MDSEL_EN, neither port SHALL exist, and every frame SHALL latch into joy_state and pulse joy_valid.

Verification (NUM_PORTS=2, BITS_PER_PORT=8, CLK_DIV=4, N=16)
REQ-034 A bench SHALL drive mode_local=1 with joy_data modelling a 16-bit chain loaded with 16'hFFFE; the required response is joy_state=16'h0001 and joy_valid pulses every 136 clks.
REQ-035 A bench SHALL check, in local scan, one joy_load_n low of 4 clks, then 16 joy_clk low/high pairs of 4+4 clks per frame.
REQ-036 A bench SHALL drop mode_local to 0 at bit 7; the required response is that joy_clk and joy_load_n follow xjoy_clk/xjoy_load_n the same cycle, with no joy_valid and joy_state unchanged.
REQ-037 A bench SHALL assert reset during SHIFT_HI; the required response is all outputs at reset values the next clk, and the first joy_valid 136 clks after release with mode_local=1.
REQ-038 A bench SHALL toggle joy_data with mode_local=0; the required response is that xjoy_data mirrors it with zero latency.
REQ-039 With JOY_MDSEL_EN, a bench SHALL alternate chain data 16'h00FF and 16'hFF00 per frame; the required response is joy_state=16'hFF00, joy_state_ext=16'h00FF, and joy_valid every 272 clks.

Source files
------------

// File: rtl/joy_scanner.sv
`default_nettype none
// ============================================================================
// Module : joy_scanner
// DB9 joystick shift-register chain scanner with I/O-controller pass-through.
// Optional macro JOY_MDSEL_EN adds joy_select and a second latched frame bank.
// Revision: 1.0
// ============================================================================
module joy_scanner #(
    parameter int NUM_PORTS     = 2,
    parameter int BITS_PER_PORT = 8,
    parameter int CLK_DIV       = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 mode_local,
    input  logic                                 xjoy_clk,
    input  logic                                 xjoy_load_n,
    input  logic                                 joy_data,
    output logic                                 joy_clk,
    output logic                                 joy_load_n,
    output logic                                 xjoy_data,
    output logic [NUM_PORTS*BITS_PER_PORT-1:0]   joy_state,
`ifdef JOY_MDSEL_EN
    output logic                                 joy_select,
    output logic [NUM_PORTS*BITS_PER_PORT-1:0]   joy_state_ext,
`endif
    output logic                                 joy_valid
);

    localparam int c_num_bits = NUM_PORTS * BITS_PER_PORT;
    localparam int c_cnt_w    = $clog2(CLK_DIV);
    localparam int c_bit_w    = $clog2(c_num_bits + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [c_cnt_w-1:0]      r_tick_cnt;
    logic                    w_tick;
    logic [c_bit_w-1:0]      r_bit;
    logic [c_num_bits-1:0]   r_shift;
    logic [c_num_bits-1:0]   w_shift_nxt;
    logic [c_num_bits-1:0]   r_state_bits;
    logic                    r_valid;
    logic                    r_clk;
    logic                    r_load_n;
    logic                    w_latch;
    logic                    w_valid_nxt;
`ifdef JOY_MDSEL_EN
    logic                    r_select;
    logic [c_num_bits-1:0]   r_state_ext;
`endif

    assign w_tick = (r_tick_cnt == c_cnt_w'(CLK_DIV - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_tick) w_next = LOAD;
            LOAD:     if (w_tick) w_next = SHIFT_LO;
            SHIFT_LO: if (w_tick) w_next = SHIFT_HI;
            SHIFT_HI: begin
                if (w_tick) begin
                    w_next = (r_bit == c_bit_w'(c_num_bits - 1)) ? DONE : SHIFT_LO;
                end
            end
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
        // Forwarding mode owns the chain, so any local scan is abandoned at once.
        if (!mode_local) begin
            w_next = IDLE;
        end
    end

    always_comb begin
        w_shift_nxt    = r_shift << 1;
        w_shift_nxt[0] = joy_data;
    end

    assign w_latch = (w_next == DONE);
`ifdef JOY_MDSEL_EN
    assign w_valid_nxt = w_latch && !r_select;
`else
    assign w_valid_nxt = w_latch;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_state_bits <= '0;
            r_valid      <= 1'b0;
            r_clk        <= 1'b1;
            r_load_n     <= 1'b1;
`ifdef JOY_MDSEL_EN
            r_select     <= 1'b1;
            r_state_ext  <= '0;
`endif
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_cnt_w'(1);
            r_state    <= w_next;
            // Pin levels are decoded from the next state so they track r_state exactly.
            r_load_n   <= (w_next != LOAD);
            r_clk      <= (w_next != SHIFT_LO);
            r_valid    <= w_valid_nxt;
            if (r_state == LOAD && w_tick) begin
                r_bit <= '0;
            end
            if (r_state == SHIFT_LO && w_tick && mode_local) begin
                r_shift <= w_shift_nxt;
            end
            if (r_state == SHIFT_HI && w_tick) begin
                r_bit <= r_bit + c_bit_w'(1);
            end
            if (w_latch) begin
`ifdef JOY_MDSEL_EN
                if (r_select) begin
                    r_state_bits <= ~r_shift;
                end else begin
                    r_state_ext  <= ~r_shift;
                end
                r_select <= ~r_select;
`else
                r_state_bits <= ~r_shift;
`endif
            end
        end
    end

    assign joy_clk    = mode_local ? r_clk    : xjoy_clk;
    assign joy_load_n = mode_local ? r_load_n : xjoy_load_n;
    assign xjoy_data  = joy_data;
    assign joy_state  = r_state_bits;
    assign joy_valid  = r_valid;
`ifdef JOY_MDSEL_EN
    assign joy_select    = r_select;
    assign joy_state_ext = r_state_ext;
`endif

endmodule
`default_nettype wire
